// File: rtl/subleq_sequencer_if.sv
// Word-addressed memory port between the SUBLEQ sequencer and its memory.
// The master issues requests. The slave answers with ready, and with rdata on reads.
interface subleq_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/subleq_sequencer.sv
// SUBLEQ control sequencer: fetches (A, B, C) at pc and reads mem[A] and mem[B].
// It feeds both operands to an external combinational subtractor.
// It writes b - a back to mem[B], then branches to C on result <= 0.
// A new pc with its MSB set parks the machine in HALT.
//
// state     | meaning
// S_IDLE    | out of reset, waiting for start
// S_FETCH_A | read mem[pc]   -> reg_a
// S_FETCH_B | read mem[pc+1] -> reg_b
// S_FETCH_C | read mem[pc+2] -> reg_c
// S_READ_A  | read mem[reg_a] -> op_a
// S_READ_B  | read mem[reg_b] -> op_b
// S_WRITE   | write alu_result -> mem[reg_b], then update pc/instr_count
// S_HALT    | stopped on a negative pc, start restarts from RESET_PC
module subleq_sequencer #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  subleq_sequencer_if.master mem_bus,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  input  logic [WIDTH-1:0]   i_alu_result,
  input  logic               i_alu_zero,
  input  logic               i_alu_negative,
  output logic               o_busy,
  output logic               o_halted,
  output logic [WIDTH-1:0]   o_pc,
  output logic [31:0]        o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_READ_A,
    S_READ_B,
    S_WRITE,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_reg_a;
  logic [WIDTH-1:0] r_reg_b;
  logic [WIDTH-1:0] r_reg_c;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [31:0]      r_instr_count;

  logic             w_req;
  logic             w_we;
  logic [WIDTH-1:0] w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_accept;
  logic             w_take;
  logic [WIDTH-1:0] w_pc_next;

  // Ready only counts while a request is actually being presented.
  assign w_accept  = w_req & mem_bus.ready;
  assign w_take    = i_alu_zero | i_alu_negative;
  assign w_pc_next = w_take ? r_reg_c : (r_pc + WIDTH'(3));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and memory request outputs.
  // All outputs depend only on state and registers, so they stay frozen during a stall.
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_FETCH_A;
      end
      S_FETCH_A: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (mem_bus.ready) w_next_state = S_FETCH_B;
      end
      S_FETCH_B: begin
        w_req  = 1'b1;
        w_addr = r_pc + WIDTH'(1);
        if (mem_bus.ready) w_next_state = S_FETCH_C;
      end
      S_FETCH_C: begin
        w_req  = 1'b1;
        w_addr = r_pc + WIDTH'(2);
        if (mem_bus.ready) w_next_state = S_READ_A;
      end
      S_READ_A: begin
        w_req  = 1'b1;
        w_addr = r_reg_a;
        if (mem_bus.ready) w_next_state = S_READ_B;
      end
      S_READ_B: begin
        w_req  = 1'b1;
        w_addr = r_reg_b;
        if (mem_bus.ready) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_reg_b;
        w_wdata = i_alu_result;
        if (mem_bus.ready) w_next_state = w_pc_next[WIDTH-1] ? S_HALT : S_FETCH_A;
      end
      S_HALT: begin
        if (i_start) w_next_state = S_FETCH_A;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath registers: capture read data on accept, commit pc/count on write accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_reg_a       <= '0;
      r_reg_b       <= '0;
      r_reg_c       <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_instr_count <= '0;
    end else begin
      if (w_accept) begin
        unique case (r_state)
          S_FETCH_A: r_reg_a <= mem_bus.rdata;
          S_FETCH_B: r_reg_b <= mem_bus.rdata;
          S_FETCH_C: r_reg_c <= mem_bus.rdata;
          S_READ_A:  r_op_a  <= mem_bus.rdata;
          S_READ_B:  r_op_b  <= mem_bus.rdata;
          S_WRITE: begin
            r_pc          <= w_pc_next;
            r_instr_count <= r_instr_count + 32'd1;
          end
          default: ;
        endcase
      end
      if (r_state == S_HALT && i_start) begin
        r_pc          <= RESET_PC;
        r_instr_count <= '0;
      end
    end
  end

  assign mem_bus.req   = w_req;
  assign mem_bus.we    = w_we;
  assign mem_bus.addr  = w_addr;
  assign mem_bus.wdata = w_wdata;

  assign o_alu_a       = r_op_a;
  assign o_alu_b       = r_op_b;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_halted      = (r_state == S_HALT);
  assign o_pc          = r_pc;
  assign o_instr_count = r_instr_count;

endmodule

// File: doc/subleq_sequencer.md
# subleq_sequencer

Control sequencer that drives the 64-bit SUBLEQ subtractor and consumes its flags. It fetches the three-word instruction (A, B, C) at pc, reads mem[A] and mem[B], and presents them to the ALU as alu_a and alu_b. It writes alu_result back to mem[B] and then branches to C when the result is ≤ 0, otherwise advancing to pc+3. It sits between the word-addressed memory port and the combinational subtractor.

## Interface
- WIDTH, 64: data, address and pc width.
- RESET_PC, 0: pc value loaded on reset and on restart.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution. Sampled only in IDLE and HALT.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req is high.
- mem_addr  out  WIDTH  word address.
- mem_wdata  out  WIDTH  write data.
- mem_ready  in  1  memory accepts or completes the request this cycle.
- mem_rdata  in  WIDTH  read data. Valid in the cycle mem_ready=1 on a read.
- alu_a  out  WIDTH  subtrahend: registered mem[A].
- alu_b  out  WIDTH  minuend: registered mem[B].
- alu_result  in  WIDTH  b − a from the ALU.
- alu_zero  in  1  result == 0.
- alu_negative  in  1  result MSB.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- pc  out  WIDTH  current instruction address.
- instr_count  out  32  completed instructions. Wraps mod 2^32.

## Operation
- States:
  - IDLE
  - FETCH_A: read pc → regA
  - FETCH_B: read pc+1 → regB
  - FETCH_C: read pc+2 → regC
  - READ_A: read regA → opA
  - READ_B: read regB → opB
  - WRITE: write alu_result → mem[regB]
  - HALT
- Reset:
  - state=IDLE, pc=RESET_PC.
  - All other outputs and registers 0, including mem_req, mem_we, mem_addr, mem_wdata, alu_a, alu_b, busy, halted and instr_count.
- IDLE:
  - start=1 → FETCH_A.
  - start=0 → stay in IDLE.
- Memory states:
  - mem_req=1 for the whole time the FSM is in the state.
  - mem_addr, mem_we and mem_wdata are held stable until mem_ready=1.
  - On mem_ready=1 the read data is captured into the target register and the FSM advances to the next state.
  - mem_ready while mem_req=0 is ignored.
- alu_a and alu_b are always driven from opA and opB.
- WRITE:
  - mem_we=1, mem_wdata=alu_result, mem_addr=regB.
  - On accept, with take = alu_zero | alu_negative:
    - pc ← take ? regC : pc+3. pc+3 wraps mod 2^WIDTH.
    - instr_count ← instr_count + 1.
  - If the new pc has bit WIDTH-1 set → HALT; otherwise → FETCH_A.
- HALT:
  - start=1 → pc ← RESET_PC, instr_count ← 0, go to FETCH_A.
  - Otherwise stay in HALT.
- Aliasing:
  - A == B is legal: the result is 0 and the branch is taken.
  - B may equal pc..pc+2 (self-modifying code). The write is visible to the next fetch.
- Register arithmetic is unsigned WIDTH-bit; the sign is taken only from alu_negative.
- Reset mid-transaction:
  - Takes priority over everything. mem_req is low from the next cycle; any partial instruction is abandoned.
  - Memory must tolerate a dropped request.

## Timing
- Moore outputs: mem_* and busy are functions of the registered state and registers.
- The request is visible in the first cycle of each memory state.
- Back-to-back transfers are allowed: a new request is issued the cycle after the previous mem_ready.
- With mem_ready tied high:
  - One instruction = 6 cycles (FETCH_A through WRITE).
  - pc and instr_count update on the WRITE accept edge.
- start to first mem_req: 1 cycle.
- Every cycle with mem_ready=0 adds exactly one cycle of stall; no output changes during the stall.
- halted rises the cycle after the WRITE accept that produced the negative pc.
- The ALU is combinational. Its flags are sampled in the same edge as the WRITE accept; no extra pipeline stage.

## Test plan
- Positive result, no branch:
  - Stimulus: mem[0..2]={10,11,20}, mem[10]=3, mem[11]=5, start pulse, ready tied high.
  - Required: write mem[11]=2, pc=3, instr_count=1. The write accept happens 6 cycles after FETCH_A entry.
- Zero result: mem[10]=5, mem[11]=5 → mem[11]=0, pc=20.
- Negative result: mem[10]=7, mem[11]=5 → mem[11]=0xFFFF_FFFF_FFFF_FFFE, pc=20.
- Halt then restart:
  - Stimulus: C=0x8000_0000_0000_0000 with the branch taken.
  - Required: halted=1, busy=0, pc=C, no further mem_req. A start pulse then gives pc=RESET_PC, instr_count=0 and mem_req the next cycle.
- Stall:
  - Stimulus: hold mem_ready=0 for 3 cycles during FETCH_B.
  - Required: mem_addr=1 and mem_req=1 held stable for 4 cycles. Total instruction time 9 cycles.
- Reset mid-WRITE:
  - Stimulus: assert rst while mem_we=1, mem_req=1.
  - Required: next cycle mem_req=0, pc=RESET_PC, state IDLE, instr_count=0.
